// File: rtl/sha256_compress_iter_pkg.sv
// Shared SHA-256 constants, types and bit-mixing functions for the iterative compressor.
package sha256_compress_iter_pkg;

  typedef logic [7:0][31:0]  state_t;   // [7]=a ... [0]=h
  typedef logic [15:0][31:0] window_t;  // [15]=oldest word ... [0]=newest word

  localparam state_t H0 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K256 [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotate_right(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Lower-case sigmas feed the message schedule, upper-case Sigmas feed the rounds.
  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return rotate_right(x, 7) ^ rotate_right(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return rotate_right(x, 17) ^ rotate_right(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] Sigma0(input logic [31:0] x);
    return rotate_right(x, 2) ^ rotate_right(x, 13) ^ rotate_right(x, 22);
  endfunction

  function automatic logic [31:0] Sigma1(input logic [31:0] x);
    return rotate_right(x, 6) ^ rotate_right(x, 11) ^ rotate_right(x, 25);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round; chained UNROLL times by the compressor top.
module sha256_round
  import sha256_compress_iter_pkg::*;
(
  input  state_t      state_in,
  input  logic [31:0] ki,
  input  logic [31:0] wi,
  output state_t      state_out
);

  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] ch, maj, temp1, temp2;

  always_comb begin
    {a, b, c, d, e, f, g, h} = state_in;
    ch        = (e & f) ^ (~e & g);
    maj       = (a & b) ^ (a & c) ^ (b & c);
    temp1     = h + Sigma1(e) + ch + ki + wi;
    temp2     = Sigma0(a) + maj;
    state_out = {temp1 + temp2, a, b, c, d + temp1, e, f, g};
  end

endmodule

// File: rtl/sha256_compress_iter.sv
// Iterative SHA-256 compression, UNROLL rounds per clock, valid/ready on both sides.
// Define SHA256_CHAIN_EN to add in_first and chain each block from the previous digest.
module sha256_compress_iter
  import sha256_compress_iter_pkg::*;
#(
  parameter int unsigned UNROLL = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0][31:0]   hash_in,
  input  logic [15:0][31:0]  block_in,
`ifdef SHA256_CHAIN_EN
  input  logic               in_first,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0][31:0]   digest_out
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} fsm_e;

  fsm_e        state_q, state_d;
  logic [6:0]  rnd_q, rnd_d;
  logic        out_valid_q, out_valid_d;
  state_t      digest_q, digest_d;
  state_t      work_q, ff_q, init_state, final_state;
  window_t     win_q, final_win;
  logic        accept, last_rnd;

  assign accept   = (state_q == StIdle) && in_valid;
  assign last_rnd = (state_q == StRun) && ((rnd_q + 7'(UNROLL)) == 7'd64);

`ifdef SHA256_CHAIN_EN
  state_t chain_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= H0;
    end else if (last_rnd) begin
      chain_q <= digest_d;
    end
  end

  assign init_state = in_first ? hash_in : chain_q;
`else
  assign init_state = hash_in;
`endif

  // Each stage consumes the oldest window word and appends one freshly scheduled word.
  for (genvar i = 0; i < UNROLL; i++) begin : g_stage
    state_t      st_in, st_out;
    window_t     win_in, win_out;
    logic [5:0]  kidx;
    logic [31:0] w_new;

    if (i == 0) begin : g_head
      assign st_in  = work_q;
      assign win_in = win_q;
    end else begin : g_tail
      assign st_in  = g_stage[i-1].st_out;
      assign win_in = g_stage[i-1].win_out;
    end

    assign kidx    = rnd_q[5:0] + 6'(i);
    assign w_new   = sigma1(win_in[1]) + win_in[6] + sigma0(win_in[14]) + win_in[15];
    assign win_out = {win_in[14:0], w_new};

    sha256_round u_round (
      .state_in  (st_in),
      .ki        (K256[kidx]),
      .wi        (win_in[15]),
      .state_out (st_out)
    );
  end

  assign final_state = g_stage[UNROLL-1].st_out;
  assign final_win   = g_stage[UNROLL-1].win_out;

  always_comb begin
    state_d     = state_q;
    rnd_d       = rnd_q;
    out_valid_d = out_valid_q;
    digest_d    = digest_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = StRun;
          rnd_d   = '0;
        end
      end
      StRun: begin
        rnd_d = rnd_q + 7'(UNROLL);
        if (last_rnd) begin
          state_d     = StDone;
          out_valid_d = 1'b1;
          for (int j = 0; j < 8; j++) begin
            digest_d[j] = ff_q[j] + final_state[j];
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rnd_q       <= '0;
      out_valid_q <= 1'b0;
      digest_q    <= '0;
    end else begin
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      out_valid_q <= out_valid_d;
      digest_q    <= digest_d;
    end
  end

  // Datapath registers carry no reset; they are always loaded on accept before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      work_q <= init_state;
      ff_q   <= init_state;
      win_q  <= block_in;
    end else if (state_q == StRun) begin
      work_q <= final_state;
      win_q  <= final_win;
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = out_valid_q;
  assign digest_out = digest_q;

endmodule
